// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and byte helpers for the LCD screen refresher.
package lcd_pkg;

  localparam logic [7:0] LCD_CMD_SET_DDRAM = 8'h80;
  localparam logic [7:0] LCD_ROW1_BASE     = 8'h40;
  localparam logic [7:0] ASCII_SPACE       = 8'h20;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    RD,
    WAIT,
    DATA,
    FIN
  } state_t;

  // Set-DDRAM-address command for the start of the given row.
  function automatic logic [7:0] row_cmd(input logic row);
    return LCD_CMD_SET_DDRAM | (row ? LCD_ROW1_BASE : 8'h00);
  endfunction

  // Non-printable buffer contents are shown as blanks.
  function automatic logic [7:0] printable(input logic [7:0] b);
    return (b < 8'h20 || b > 8'h7E) ? ASCII_SPACE : b;
  endfunction

endpackage

// File: rtl/lcd_refresh.sv
// Streams the display buffer to the LCD controller: per row a DDRAM address command, then COLS characters.
// Three cycles per character (address, read, offer); valid/ready handshake, lcd_ready low stalls losslessly.
module lcd_refresh
  import lcd_pkg::*;
#(
  parameter  int COLS = 16,
  parameter  int ROWS = 2,
  localparam int AW   = $clog2(COLS*ROWS)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  output logic [AW-1:0] buf_addr,
  input  logic [7:0]    buf_dout,
  output logic          lcd_valid,
  output logic [7:0]    lcd_data,
  output logic          lcd_is_data,
  input  logic          lcd_ready,
  output logic          busy,
  output logic          done
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  state_t          state, state_nxt;
  logic            pending;
  logic [CW-1:0]   col;
  logic            row;
  logic [AW-1:0]   addr;
  logic [7:0]      data_q;
  logic            last_col, last_row, launch;

  assign last_col = (col == CW'(COLS-1));
  assign last_row = (row == 1'(ROWS-1));
  assign launch   = (state == IDLE && start) || (state == FIN && (pending || start));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CMD;
      CMD:     if (lcd_ready) state_nxt = RD;
      RD:      state_nxt = WAIT;
      WAIT:    state_nxt = DATA;
      DATA:    if (lcd_ready) state_nxt = !last_col ? RD : (last_row ? FIN : CMD);
      FIN:     state_nxt = (pending || start) ? CMD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    lcd_valid   = (state == CMD) || (state == DATA);
    lcd_is_data = (state == DATA);
    busy        = (state != IDLE);
    done        = (state == FIN);
    lcd_data    = data_q;
    buf_addr    = addr;
  end

  // A start arriving while busy is remembered once and consumed in FIN.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                           pending <= 1'b0;
    else if (state == FIN)               pending <= 1'b0;
    else if (start && state != IDLE)     pending <= 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col    <= '0;
      row    <= 1'b0;
      addr   <= '0;
      data_q <= 8'h00;
    end else if (launch) begin
      col    <= '0;
      row    <= 1'b0;
      addr   <= '0;
      data_q <= row_cmd(1'b0);
    end else if (state == WAIT) begin
      data_q <= printable(buf_dout);
    end else if (state == DATA && lcd_ready) begin
      if (!last_col) begin
        col  <= col + CW'(1);
        addr <= addr + AW'(1);
      end else if (last_row) begin
        col  <= '0;
        row  <= 1'b0;
        addr <= '0;
      end else begin
        // Next row's address command is loaded so CMD can offer it straight away.
        col    <= '0;
        row    <= 1'b1;
        addr   <= addr + AW'(1);
        data_q <= row_cmd(1'b1);
      end
    end
  end

endmodule

// File: tb/tb_lcd_refresh.sv
// Scoreboard bench: expected LCD byte streams are queued at start and popped as the DUT hands bytes over.
module tb_lcd_refresh;

  logic       clk, rstn;
  logic       start0, ready0, busy0, done0, valid0, isd0;
  logic [7:0] data0, dout0;
  logic [4:0] addr0;
  logic       start1, busy1, done1, valid1, isd1;
  logic       ready1 = 1'b1;
  logic [7:0] data1, dout1;
  logic [2:0] addr1;

  logic [7:0] mem0 [32];
  logic [7:0] mem1 [8];
  logic [8:0] q0 [$];
  logic [8:0] q1 [$];

  int vectors, errors, done_cnt, data_seen, rmode;
  logic       prev_stall;
  logic [8:0] prev_word;

  lcd_refresh dut0 (
    .clk(clk), .rstn(rstn), .start(start0), .buf_addr(addr0), .buf_dout(dout0),
    .lcd_valid(valid0), .lcd_data(data0), .lcd_is_data(isd0), .lcd_ready(ready0),
    .busy(busy0), .done(done0)
  );

  lcd_refresh #(.COLS(8), .ROWS(1)) dut1 (
    .clk(clk), .rstn(rstn), .start(start1), .buf_addr(addr1), .buf_dout(dout1),
    .lcd_valid(valid1), .lcd_data(data1), .lcd_is_data(isd1), .lcd_ready(ready1),
    .busy(busy1), .done(done1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    dout0 <= mem0[addr0];
    dout1 <= mem1[addr1];
  end

  initial begin
    ready0 = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready0 = (rmode == 0) ? 1'b1 : ($urandom_range(0, 9) < 3);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] shown(input logic [7:0] b);
    return (b >= 8'h20 && b <= 8'h7E) ? b : 8'h20;
  endfunction

  task automatic push_frame();
    for (int r = 0; r < 2; r++) begin
      q0.push_back({1'b0, (r == 0) ? 8'h80 : 8'hC0});
      for (int c = 0; c < 16; c++) q0.push_back({1'b1, shown(mem0[r*16+c])});
    end
  endtask

  task automatic load0(input int base, input string s);
    for (int i = 0; i < s.len(); i++) mem0[base+i] = s[i];
  endtask

  always @(negedge clk) begin
    logic [8:0] exp;
    if (!rstn) prev_stall = 1'b0;
    else begin
      if (done0) done_cnt++;
      if (prev_stall) begin
        chk("hold_valid", valid0, 1);
        chk("hold_byte", {isd0, data0}, prev_word);
      end
      if (valid0 && ready0) begin
        if (q0.size() == 0) chk("extra_byte", q0.size(), 1);
        else begin
          exp = q0.pop_front();
          chk("byte", {isd0, data0}, exp);
        end
        if (isd0) data_seen++;
      end
      prev_stall = valid0 && !ready0;
      prev_word  = {isd0, data0};
    end
  end

  always @(negedge clk) begin
    logic [8:0] exp;
    if (rstn && valid1 && ready1) begin
      if (q1.size() == 0) chk("extra_byte_1row", q1.size(), 1);
      else begin
        exp = q1.pop_front();
        chk("byte_1row", {isd1, data1}, exp);
      end
    end
  end

  task automatic drain0();
    int n = 0;
    while ((q0.size() != 0 || busy0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_q", q0.size(), 0);
    chk("idle_after", busy0, 0);
  endtask

  task automatic refresh0(input int exp_lat);
    int cyc;
    push_frame();
    @(posedge clk); #1 start0 = 1'b1;
    @(negedge clk); cyc = 1;
    @(posedge clk); #1 start0 = 1'b0;
    while (!done0 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", done0, 1);
    if (exp_lat > 0) chk("latency", cyc, exp_lat);
    drain0();
  endtask

  initial begin
    int dc, n, gaps, cyc;
    vectors = 0; errors = 0; done_cnt = 0; data_seen = 0; rmode = 0;
    prev_stall = 1'b0; prev_word = '0;
    rstn = 1'b0; start0 = 1'b0; start1 = 1'b0;
    for (int i = 0; i < 32; i++) mem0[i] = 8'h20;
    load0(0, "Hello");
    load0(16, "Worl");
    mem1 = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h7F, 8'h47, 8'h48};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", valid0, 0);
    chk("rst_data", data0, 0);
    chk("rst_is_data", isd0, 0);
    chk("rst_addr", addr0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_valid_1row", valid1, 0);
    rstn = 1'b1;
    repeat (2) @(posedge clk);

    // Hello/World with ready tied high
    dc = done_cnt;
    refresh0(100);
    chk("done_pulses", done_cnt - dc, 1);

    // Same stream under a 30% ready duty
    rmode = 1;
    refresh0(0);
    rmode = 0;

    // Non-printable bytes become spaces
    mem0[3] = 8'h0A; mem0[20] = 8'hFF;
    refresh0(100);
    mem0[3] = "l";   mem0[20] = 8'h20;

    // Three starts mid-refresh collapse into a single rerun
    dc = done_cnt;
    push_frame(); push_frame();
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    repeat (20) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      #1 start0 = 1'b1;
      @(posedge clk); #1 start0 = 1'b0;
      repeat (4) @(posedge clk);
    end
    n = 0; gaps = 0;
    while (done_cnt - dc < 2 && n < 3000) begin
      @(negedge clk); #1;
      n++;
      if (!busy0) gaps++;
    end
    chk("busy_gap", gaps, 0);
    chk("two_done", done_cnt - dc, 2);
    drain0();
    repeat (5) @(posedge clk);
    chk("no_third_run", done_cnt - dc, 2);

    // Reset while the 10th character is offered
    push_frame();
    data_seen = 0;
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    n = 0;
    while (!(valid0 && isd0 && data_seen == 9) && n < 2000) begin
      @(posedge clk); #2;
      n++;
    end
    chk("reach_byte10", data_seen, 9);
    rstn = 1'b0;
    #1;
    chk("rst_mid_valid", valid0, 0);
    chk("rst_mid_busy", busy0, 0);
    chk("rst_mid_data", data0, 0);
    chk("rst_mid_addr", addr0, 0);
    chk("abandoned_bytes", q0.size(), 24);
    q0.delete();
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("no_autostart", busy0, 0);
    refresh0(100);

    // Single-row, 8-column instance
    q1.push_back({1'b0, 8'h80});
    for (int c = 0; c < 8; c++) q1.push_back({1'b1, shown(mem1[c])});
    @(posedge clk); #1 start1 = 1'b1;
    @(negedge clk); cyc = 1;
    @(posedge clk); #1 start1 = 1'b0;
    while (!done1 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency_1row", cyc, 27);
    n = 0;
    while ((q1.size() != 0 || busy1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_q_1row", q1.size(), 0);
    chk("idle_1row", busy1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/lcd_refresh.md
LCD_REFRESH -- requirements
Module: lcd_refresh

Interface
REQ-001 Parameter COLS, default 16, characters per LCD row.
REQ-002 Parameter ROWS, default 2, number of LCD rows; legal values are 1 or 2.
REQ-003 Localparam AW = $clog2(COLS*ROWS) SHALL be the width of the buffer address.
REQ-004 clk  input  1  single system clock (12 MHz); all logic SHALL be on its rising edge.
REQ-005 rstn  input  1  reset, asynchronous assert, active-low.
REQ-006 start  input  1  single-cycle request to redraw the whole screen.
REQ-007 buf_addr  output  AW  read address into display_buffer.
REQ-008 buf_dout  input  8  display_buffer read data, valid one cycle after buf_addr.
REQ-009 lcd_valid  output  1  byte offered to lcd_ctrl.
REQ-010 lcd_data  output  8  byte offered to lcd_ctrl.
REQ-011 lcd_is_data  output  1  1 = character write, 0 = command.
REQ-012 lcd_ready  input  1  lcd_ctrl accepts the byte when lcd_valid && lcd_ready at a rising edge.
REQ-013 busy  output  1  refresh in progress.
REQ-014 done  output  1  one-cycle pulse when a refresh completes.

Function
REQ-015 A refresh SHALL emit, for each row r = 0..ROWS-1 in order:
- command 0x80 | base(r), with base(0) = 0x00 and base(1) = 0x40;
- then COLS data bytes read from addresses r*COLS .. r*COLS+COLS-1.
REQ-016 State machine states SHALL be IDLE, CMD, RD, WAIT, DATA, FIN.
- IDLE->CMD on start; CMD->RD on accept.
- RD->WAIT unconditionally; WAIT->DATA unconditionally.
- DATA->RD on accept when the column is not the last.
- DATA->CMD on accept at the end of a row when the row is not the last.
- DATA->FIN on accept of the final byte.
- FIN->IDLE, or FIN->CMD when pending is set.
REQ-017 start sampled in IDLE SHALL raise busy, and lcd_valid with lcd_data=0x80 and lcd_is_data=0, on the next rising edge.
REQ-018 In RD, buf_addr SHALL be driven. buf_dout SHALL be captured in WAIT and presented in DATA with lcd_is_data=1.
REQ-019 A captured byte outside 0x20..0x7E SHALL be sent as 0x20 (space).
REQ-020 Once asserted, lcd_valid, lcd_data and lcd_is_data SHALL hold stable until accepted. lcd_valid SHALL be 0 in IDLE, RD, WAIT and FIN.
REQ-021 lcd_ready high while lcd_valid is low SHALL have no effect. lcd_ready held low SHALL stall the sequence indefinitely without data loss.
REQ-022 start while busy SHALL set a pending flag. In FIN, pending SHALL clear and a new refresh SHALL begin at row 0. Multiple starts SHALL collapse to one rerun.
REQ-023 done SHALL pulse exactly one cycle, in FIN. busy SHALL fall in the cycle after FIN only when there is no rerun. busy SHALL stay high continuously across a rerun.
REQ-024 The column counter SHALL wrap 0..COLS-1 and the row counter 0..ROWS-1. The address SHALL never exceed COLS*ROWS-1.
REQ-025 One refresh with lcd_ready tied high SHALL take exactly ROWS*(1 + 3*COLS) + 2 cycles, measured from the start edge to the edge where done is high.

Reset
REQ-026 rstn low SHALL immediately clear all outputs and state: state=IDLE, lcd_valid=0, lcd_data=0x00, lcd_is_data=0, buf_addr=0, busy=0, done=0, pending=0, counters=0.
REQ-027 Reset during a refresh SHALL abandon it. A new refresh SHALL require a fresh start after release.

Structure
REQ-028 Package lcd_pkg SHALL hold LCD_CMD_SET_DDRAM=8'h80, LCD_ROW1_BASE=8'h40, ASCII_SPACE=8'h20 and the state enum type.
REQ-029 The block SHALL be a single module with no sub-module. It SHALL connect between display_buffer (read side) and lcd_ctrl.

Verification
REQ-030 Buffer preloaded with "Hello" at addresses 0..4 and "Worl" at 16..19, spaces elsewhere, lcd_ready=1, one start:
- stream SHALL be 0x80, "Hello", 11 spaces, 0xC0, "Worl", 12 spaces;
- done SHALL rise 100 cycles after start.
REQ-031 lcd_ready toggled pseudo-randomly at 30% duty: the byte stream SHALL be identical to REQ-030, with no duplicated or dropped bytes and lcd_data stable while stalled.
REQ-032 Buffer addr 3 = 0x0A and addr 20 = 0xFF: both SHALL be emitted as 0x20.
REQ-033 start pulsed 3 times mid-refresh:
- exactly two full refreshes SHALL occur;
- busy SHALL stay continuously high;
- done SHALL pulse twice.
REQ-034 rstn asserted while the 10th data byte is pending:
- lcd_valid and busy SHALL drop immediately;
- after release, start SHALL produce a clean 0x80-led full sequence.
REQ-035 ROWS=1, COLS=8: stream SHALL be 0x80 plus 8 data bytes, with no 0xC0 command.
